// File: rtl/sar_adc_sampler.sv
// Host-side sequencer for a SAR ADC controller: periodic start pulses, result
// capture, 2^AVG_LOG2 averaging, valid/ready output and error pulses.
module sar_adc_sampler #(
  parameter int ADC_WIDTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter int AVG_LOG2  = 2,
  parameter int TIMEOUT   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 start,
  input  logic                 eoc,
  input  logic                 den,
  input  logic [ADC_WIDTH-1:0] din,
  output logic [ADC_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 trig_miss,
  output logic                 overrun
);

  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT) + 1;
  localparam logic [DIV_WIDTH-1:0] MIN_PERIOD  = DIV_WIDTH'(ADC_WIDTH + 4);
  localparam logic [CNT_W-1:0]     LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]      TO_LAST     = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT} state_t;

  state_t               state_reg;
  logic [DIV_WIDTH-1:0] div_cnt_reg;
  logic [DIV_WIDTH-1:0] period_eff;
  logic [ACC_W-1:0]     acc_reg;
  logic [ACC_W-1:0]     sum;
  logic [CNT_W-1:0]     sample_cnt_reg;
  logic [TO_W-1:0]      to_cnt_reg;
  logic [ADC_WIDTH-1:0] result;
  logic                 tick;
  logic                 capture;
  logic                 window_done;

  always_comb begin
    period_eff = (period > MIN_PERIOD) ? period : MIN_PERIOD;
  end

  // >= rather than == so a period shortened below the running count still wraps.
  assign tick        = enable && (div_cnt_reg >= period_eff - DIV_WIDTH'(1));
  assign capture     = (state_reg == WAIT) && eoc && den;
  assign sum         = acc_reg + ACC_W'(din);
  assign result      = ADC_WIDTH'(sum >> AVG_LOG2);
  assign window_done = capture && (sample_cnt_reg == LAST_SAMPLE);

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      start          <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      trig_miss      <= 1'b0;
      acc_reg        <= '0;
      sample_cnt_reg <= '0;
      to_cnt_reg     <= '0;
    end else begin
      start       <= 1'b0;
      timeout_err <= 1'b0;
      trig_miss   <= tick && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (!enable) begin
            acc_reg        <= '0;
            sample_cnt_reg <= '0;
          end
          if (tick) begin
            state_reg <= TRIG;
            start     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        TRIG: begin
          to_cnt_reg <= '0;
          state_reg  <= WAIT;
        end
        WAIT: begin
          if (capture) begin
            if (window_done) begin
              acc_reg        <= '0;
              sample_cnt_reg <= '0;
            end else begin
              acc_reg        <= sum;
              sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
            end
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (to_cnt_reg == TO_LAST) begin
            timeout_err    <= 1'b1;
            acc_reg        <= '0;
            sample_cnt_reg <= '0;
            state_reg      <= IDLE;
            busy           <= 1'b0;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: a stalled stream drops the newer average instead of the held one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (window_done) begin
        if (!m_valid || m_ready) begin
          m_data  <= result;
          m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_sampler.sv
// Bench for sar_adc_sampler: table-driven averaging windows, directed corner
// sequences and randomized traffic against a cycle-stepped reference model.
module tb_sar_adc_sampler;

  localparam int TIMEOUT = 32;
  localparam int AVG_N   = 4;
  localparam int MIN_P   = 12;

  logic        clk = 1'b0;
  logic        rst_n, enable, eoc, den, m_ready;
  logic [15:0] period;
  logic [7:0]  din;
  logic        start, busy, m_valid, timeout_err, trig_miss, overrun;
  logic [7:0]  m_data;
  logic        start0, busy0, m_valid0, timeout_err0, trig_miss0, overrun0;
  logic [7:0]  m_data0;
  logic        ready_one = 1'b1;

  always #5 clk = ~clk;

  sar_adc_sampler #(.ADC_WIDTH(8), .DIV_WIDTH(16), .AVG_LOG2(2), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .start(start),
    .eoc(eoc), .den(den), .din(din), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .timeout_err(timeout_err),
    .trig_miss(trig_miss), .overrun(overrun)
  );

  // Pass-through build shares the ADC stimulus; its FSM timing is identical.
  sar_adc_sampler #(.ADC_WIDTH(8), .DIV_WIDTH(16), .AVG_LOG2(0), .TIMEOUT(TIMEOUT)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .start(start0),
    .eoc(eoc), .den(den), .din(din), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(ready_one), .busy(busy0), .timeout_err(timeout_err0),
    .trig_miss(trig_miss0), .overrun(overrun0)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  bit         m_conv = 1'b0;
  int         s_cyc = 0;
  int         en_since = 0;
  int         win[$];
  logic       e_start = 0, e_busy = 0, e_valid = 0, e_to = 0, e_tm = 0, e_ov = 0;
  logic [7:0] e_data = 0;
  logic       e0_valid = 0;
  logic [7:0] e0_data = 0;

  // ADC model / stimulus control
  int         adc_lat = 0;
  bit         adc_force = 0, rand_lat = 0, rand_ready = 0, noise = 0;
  int         pend = -1;
  logic [7:0] adc_vals[$];

  // Event log
  int         n_start = 0, last_start = -1, last_gap = 0, n_to = 0, n_tm = 0, n_ov = 0;
  int         n_xfer = 0, n_eoc = 0, last_eoc = -1, n_valid0 = 0;
  logic [7:0] last_xfer = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Predict the outputs of the next cycle from this cycle's inputs.
  function automatic void model_update();
    int   pe, s;
    bit   tick, got, have, conv_next, nstart, nto, ntm, nov;
    logic [7:0] avg;
    pe = (int'(period) > MIN_P) ? int'(period) : MIN_P;
    if (!rst_n) begin
      m_conv = 0; win.delete(); en_since = cyc + 1;
      e_start = 0; e_busy = 0; e_valid = 0; e_data = 0; e_to = 0; e_tm = 0; e_ov = 0;
      e0_valid = 0; e0_data = 0;
      return;
    end
    tick = enable && (((cyc - en_since + 1) % pe) == 0);
    if (!enable) en_since = cyc + 1;
    nstart = 0; nto = 0; got = 0; have = 0; nov = 0; avg = 0;
    ntm = tick && m_conv;
    conv_next = m_conv;
    if (m_conv) begin
      if (cyc > s_cyc && eoc && den) begin
        got = 1; conv_next = 0;
      end else if (cyc == s_cyc + TIMEOUT) begin
        nto = 1; win.delete(); conv_next = 0;
      end
    end else begin
      if (!enable) win.delete();
      if (tick) begin
        nstart = 1; conv_next = 1; s_cyc = cyc + 1;
      end
    end
    if (got) begin
      win.push_back(int'(din));
      e0_valid = 1; e0_data = din;
      if (win.size() == AVG_N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        avg = 8'(s / AVG_N);
        have = 1;
        win.delete();
      end
    end else begin
      e0_valid = 0;
    end
    if (have) begin
      if (!e_valid || m_ready) begin
        e_valid = 1; e_data = avg;
      end else begin
        nov = 1;
      end
    end else if (e_valid && m_ready) begin
      e_valid = 0;
    end
    e_start = nstart; e_busy = conv_next; e_to = nto; e_tm = ntm; e_ov = nov;
    m_conv = conv_next;
  endfunction

  task automatic step();
    int lat;
    if (m_valid && m_ready) begin
      n_xfer++;
      last_xfer = m_data;
      $display("[TB] cycle %0d transfer m_data=%02h", cyc, m_data);
    end
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check("outputs", 64'({start, busy, m_valid, timeout_err, trig_miss, overrun, m_data}),
          64'({e_start, e_busy, e_valid, e_to, e_tm, e_ov, e_data}));
    check("passthru", 64'({start0, busy0, timeout_err0, trig_miss0, overrun0, m_valid0, m_data0}),
          64'({e_start, e_busy, e_to, e_tm, 1'b0, e0_valid, e0_data}));
    if (start) begin
      if (last_start >= 0) last_gap = cyc - last_start;
      last_start = cyc;
      n_start++;
    end
    if (timeout_err) n_to++;
    if (trig_miss) n_tm++;
    if (overrun) n_ov++;
    if (m_valid0) n_valid0++;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    if (start) begin
      if (rand_lat) lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 32));
      else lat = adc_lat;
      pend = (lat > 0) ? cyc + lat : -1;
    end
    if (adc_force) begin
      eoc = 1; den = 1; din = 8'hFF;
    end else if (pend == cyc) begin
      eoc = 1; den = 1;
      din = (adc_vals.size() > 0) ? adc_vals.pop_front() : 8'($urandom);
      n_eoc++; last_eoc = cyc; pend = -1;
    end else begin
      eoc = noise && ($urandom_range(0, 7) == 0);
      den = 0;
      din = 8'($urandom);
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  typedef struct packed {
    logic [7:0] d0, d1, d2, d3, avg;
  } avg_vec_t;

  initial begin
    avg_vec_t   avg_tbl[6];
    logic [7:0] cv[3];
    int         b, e0, v0, to0, ov0, x0, tm0;

    avg_tbl[0] = '{8'h10, 8'h20, 8'h30, 8'h41, 8'h28};
    avg_tbl[1] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    avg_tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'hFE};
    avg_tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
    avg_tbl[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h02};
    avg_tbl[5] = '{8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F};
    cv = '{8'h5A, 8'hA5, 8'h3C};

    rst_n = 0; enable = 0; period = 16'd20; eoc = 0; den = 0; din = 0; m_ready = 1;

    // Reset while the ADC side is asserting eoc/den
    adc_force = 1;
    run(3);
    check("reset_outputs", 64'({start, busy, m_valid, timeout_err, trig_miss, overrun, m_data}), 64'(0));
    adc_force = 0; rst_n = 1;
    run(2);

    // Averaging windows, period 20, ADC latency 10
    period = 16'd20; adc_lat = 10; enable = 1;
    for (int t = 0; t < 6; t++) begin
      adc_vals.push_back(avg_tbl[t].d0); adc_vals.push_back(avg_tbl[t].d1);
      adc_vals.push_back(avg_tbl[t].d2); adc_vals.push_back(avg_tbl[t].d3);
      b = 0;
      do begin step(); b++; end while (!m_valid && b < 300);
      check("avg_valid", 64'(m_valid), 64'(1));
      check("avg_data", 64'(m_data), 64'(avg_tbl[t].avg));
      check("avg_latency", 64'(cyc), 64'(last_eoc + 1));
      check("avg_start_gap", 64'(last_gap), 64'(20));
      step();
      check("avg_one_cycle", 64'(m_valid), 64'(0));
    end
    enable = 0;
    run(20);

    // Minimum period clamp and pass-through build
    period = 16'd3; adc_lat = 5; last_start = -1; enable = 1;
    for (int k = 0; k < 3; k++) adc_vals.push_back(cv[k]);
    for (int k = 0; k < 3; k++) begin
      b = 0;
      do begin step(); b++; end while (!m_valid0 && b < 40);
      check("clamp_valid0", 64'(m_valid0), 64'(1));
      check("clamp_data0", 64'(m_data0), 64'(cv[k]));
    end
    check("clamp_gap", 64'(last_gap), 64'(12));
    enable = 0;
    run(20);

    // Timeout discards the partial window
    period = 16'd40; adc_lat = 10; enable = 1;
    adc_vals.push_back(8'h10); adc_vals.push_back(8'h10);
    e0 = n_eoc; b = 0;
    do begin step(); b++; end while (n_eoc < e0 + 2 && b < 200);
    adc_lat = 0; b = 0;
    do begin step(); b++; end while (!timeout_err && b < 200);
    check("timeout_pulse", 64'(timeout_err), 64'(1));
    check("timeout_cycle", 64'(cyc), 64'(last_start + TIMEOUT + 1));
    check("timeout_busy", 64'(busy), 64'(0));
    adc_lat = 10;
    repeat (4) adc_vals.push_back(8'h80);
    b = 0;
    do begin step(); b++; end while (!m_valid && b < 400);
    check("timeout_valid", 64'(m_valid), 64'(1));
    check("timeout_no_stale", 64'(m_data), 64'(8'h80));
    enable = 0;
    run(20);

    // eoc on the last WAIT cycle wins; one cycle later it is too late
    adc_lat = 32; enable = 1; b = 0;
    do begin step(); b++; end while (!start && b < 100);
    to0 = n_to; v0 = n_valid0;
    run(36);
    check("coincident_no_timeout", 64'(n_to), 64'(to0));
    check("coincident_captured", 64'(n_valid0), 64'(v0 + 1));
    adc_lat = 33; b = 0;
    do begin step(); b++; end while (!start && b < 100);
    to0 = n_to; v0 = n_valid0;
    run(36);
    check("late_timeout", 64'(n_to), 64'(to0 + 1));
    check("late_not_captured", 64'(n_valid0), 64'(v0));
    enable = 0;
    run(40);

    // Backpressure across two windows
    m_ready = 0; period = 16'd20; adc_lat = 10;
    repeat (4) adc_vals.push_back(8'h11);
    repeat (4) adc_vals.push_back(8'h22);
    ov0 = n_ov; e0 = n_eoc; enable = 1; b = 0;
    do begin step(); b++; end while (n_eoc < e0 + 8 && b < 400);
    enable = 0;
    run(3);
    check("bp_valid", 64'(m_valid), 64'(1));
    check("bp_held", 64'(m_data), 64'(8'h11));
    check("bp_overrun", 64'(n_ov - ov0), 64'(1));
    x0 = n_xfer; m_ready = 1;
    run(3);
    check("bp_one_xfer", 64'(n_xfer - x0), 64'(1));
    check("bp_xfer_data", 64'(last_xfer), 64'(8'h11));
    check("bp_valid_drop", 64'(m_valid), 64'(0));
    run(10);

    // Ticks landing in WAIT are dropped
    period = 16'd12; adc_lat = 14; tm0 = n_tm; last_start = -1; enable = 1;
    run(100);
    check("trig_miss_seen", 64'(n_tm > tm0), 64'(1));
    check("trig_miss_gap", 64'(last_gap), 64'(24));
    enable = 0;
    run(30);

    // Reset mid-WAIT, then a late eoc
    period = 16'd20; adc_lat = 15; enable = 1; b = 0;
    do begin step(); b++; end while (!start && b < 100);
    run(5);
    rst_n = 0; enable = 0;
    run(2);
    rst_n = 1; v0 = n_valid0;
    run(20);
    check("rst_late_eoc_ignored", 64'(n_valid0), 64'(v0));
    check("rst_no_valid", 64'(m_valid), 64'(0));
    check("rst_idle", 64'(busy), 64'(0));

    // Randomized traffic against the model
    rand_ready = 1; rand_lat = 1; noise = 1;
    for (int seg = 0; seg < 8; seg++) begin
      enable = 0;
      run(int'($urandom_range(1, 5)));
      period = 16'($urandom_range(3, 60));
      enable = 1;
      run(int'($urandom_range(150, 300)));
    end
    enable = 0; rand_ready = 0; m_ready = 1; noise = 0;
    run(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_adc_sampler.md
Name: sar_adc_sampler

Overview:
- Host-side sequencer for the SAR ADC controller.
- Issues periodic one-cycle start pulses to the controller and captures each result on eoc/den.
- Averages 2^AVG_LOG2 conversions and presents the mean on a valid/ready output stream.
- Detects conversions that never complete (timeout), trigger ticks missed while busy, and results dropped because the stream was stalled (overrun).

Parameters:
ADC_WIDTH, 8, result width; must match the ADC controller.
DIV_WIDTH, 16, width of the sample-period input and period counter.
AVG_LOG2, 2, log2 of samples averaged per output; 0 gives pass-through.
TIMEOUT, 32, cycles in WAIT before a conversion is abandoned.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  sampling enable
period  in  DIV_WIDTH  sample interval in clk cycles
start  out  1  to ADC start; one-cycle high pulse per conversion
eoc  in  1  from ADC, end-of-conversion pulse
den  in  1  from ADC, result valid
din  in  ADC_WIDTH  from ADC Dout
m_data  out  ADC_WIDTH  averaged result
m_valid  out  1  m_data valid
m_ready  in  1  downstream accept
busy  out  1  high in TRIG or WAIT
timeout_err  out  1  one-cycle pulse, conversion abandoned
trig_miss  out  1  one-cycle pulse, tick arrived while not IDLE
overrun  out  1  one-cycle pulse, averaged result dropped

Behaviour:
- Reset (rst_n low at posedge): all outputs 0, state IDLE, all counters, accumulator and output register cleared. Reset mid-conversion abandons it; a late eoc from the ADC is ignored because the state is IDLE.
- Period counter:
  - period_eff = max(period, ADC_WIDTH+4).
  - While enable=1, div_cnt increments. When div_cnt == period_eff-1, tick=1 and div_cnt wraps to 0.
  - enable=0 holds div_cnt at 0; no ticks.
  - period is sampled every cycle, so a change takes effect at the next compare.
- FSM states: IDLE, TRIG, WAIT.
  - IDLE: a tick moves to TRIG. If enable=0, acc and sample_cnt are cleared.
  - TRIG: start=1 for exactly this cycle; timeout counter cleared; next state WAIT.
  - WAIT: start=0.
    - If eoc&&den: acc += din, sample_cnt++, return to IDLE.
    - Else if the timeout counter reaches TIMEOUT-1: timeout_err=1, acc and sample_cnt cleared, return to IDLE.
    - eoc without den is ignored.
    - eoc and timeout in the same cycle: eoc wins.
- start is registered: tick at cycle T gives start high at T+1 only.
- Any tick while state != IDLE produces trig_miss=1 for one cycle and is dropped; it is not queued.
- Accumulator:
  - Width ADC_WIDTH+AVG_LOG2, unsigned; it cannot overflow.
  - On the capture that makes sample_cnt == 2^AVG_LOG2, result = (acc+din) >> AVG_LOG2 (truncating). acc and sample_cnt then clear.
- Output register, independent of the FSM:
  - If m_valid=0, or m_valid&&m_ready in the same cycle, load result; m_valid=1 on the next cycle.
  - Otherwise drop result, pulse overrun, and leave m_data/m_valid unchanged.
  - m_valid&&m_ready with no new result clears m_valid.
  - m_data is held stable while m_valid=1 && m_ready=0.
- Latency: eoc of the final sample at cycle E gives m_valid=1 at E+1.
- enable falling mid-WAIT: the in-flight conversion completes and is captured. Back in IDLE with enable=0, the partial average is discarded.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while the ADC model drives eoc/den=1 -> start, m_valid, busy, timeout_err, trig_miss, overrun and m_data all 0.
- Averaging: enable=1, period=20; the ADC model answers each start after 10 cycles with 0x10, 0x20, 0x30, 0x41, m_ready=1 -> start pulses exactly 20 cycles apart, each 1 cycle wide; m_data=0x28 (161>>2) with m_valid=1 for 1 cycle, on the cycle after the 4th eoc.
- Min period clamp: period=3 -> start spacing 12 cycles; AVG_LOG2=0 build gives m_data equal to each din.
- Timeout: model ignores start -> timeout_err pulse on the 32nd WAIT cycle, busy drops. A subsequent good sample 0x80 x4 yields m_data=0x80 (no stale partial sum).
- Backpressure: m_ready=0 across two averaging windows (0x11 x4 then 0x22 x4) -> first m_data=0x11 held; overrun pulses once; after m_ready=1, one transfer of 0x11 and m_valid drops.
- Boundaries:
  - period=12 with model latency 14 -> trig_miss on ticks landing in WAIT.
  - eoc coincident with timeout -> sample captured, no timeout_err.
  - rst_n low mid-WAIT, then a late eoc -> ignored, no m_valid.
